uart_tx_serializer: RTL and testbench

- 8N1 (optionally 8E1/8O1) UART transmit serializer, LSB first.
- Sits directly downstream of the hold-timer stage. It consumes that stage's one-cycle transmit pulse together with a parallel byte and drives the board TX pin.
- Reports busy status and a one-cycle completion pulse so upstream logic can chain frames.

---
 rtl/uart_tx_serializer.sv | 140 ++++++++++++++
 tb/tb_uart_tx_serializer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// All outputs are registered; a start request is only honoured while idle.
module uart_tx_serializer #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter bit          PARITY_EN    = 1'b0,
    parameter bit          PARITY_ODD   = 1'b0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Tx_Start,
    input  logic [7:0] i_Tx_Byte,
    output logic       o_Tx_Serial,
    output logic       o_Tx_Active,
    output logic       o_Tx_Done
);

    localparam int unsigned   CntW   = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    StopMax = 3'(STOP_BITS - 1);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StStart  = 3'd1;
    localparam logic [2:0] StData   = 3'd2;
    localparam logic [2:0] StParity = 3'd3;
    localparam logic [2:0] StStop   = 3'd4;

    logic [2:0]      state_q, state_d;
    logic [CntW-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            serial_q, serial_d;
    logic            active_q, active_d;
    logic            done_q, done_d;
    logic            bit_end;

    assign bit_end = (clk_cnt_q == CntMax);

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = bit_end ? '0 : clk_cnt_q + 1'b1;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        serial_d  = serial_q;
        active_d  = active_q;
        done_d    = 1'b0;

        case (state_q)
            StIdle: begin
                clk_cnt_d = '0;
                serial_d  = 1'b1;
                active_d  = 1'b0;
                if (i_Tx_Start) begin
                    shift_d   = i_Tx_Byte;
                    bit_idx_d = '0;
                    state_d   = StStart;
                    serial_d  = 1'b0;
                    active_d  = 1'b1;
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d   = StData;
                    bit_idx_d = '0;
                    serial_d  = shift_q[0];
                end
            end
            StData: begin
                if (bit_end) begin
                    if (bit_idx_q == 3'd7) begin
                        // Index wraps to 0 here and is reused to count stop bits.
                        bit_idx_d = '0;
                        if (PARITY_EN) begin
                            state_d  = StParity;
                            serial_d = (^shift_q) ^ PARITY_ODD;
                        end else begin
                            state_d  = StStop;
                            serial_d = 1'b1;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        serial_d  = shift_q[bit_idx_q + 3'd1];
                    end
                end
            end
            StParity: begin
                if (bit_end) begin
                    state_d   = StStop;
                    bit_idx_d = '0;
                    serial_d  = 1'b1;
                end
            end
            StStop: begin
                serial_d = 1'b1;
                if (bit_end) begin
                    if (bit_idx_q == StopMax) begin
                        state_d   = StIdle;
                        bit_idx_d = '0;
                        active_d  = 1'b0;
                        done_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d   = StIdle;
                clk_cnt_d = '0;
                bit_idx_d = '0;
                serial_d  = 1'b1;
                active_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q   <= StIdle;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            serial_q  <= 1'b1;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            serial_q  <= serial_d;
            active_q  <= active_d;
            done_q    <= done_d;
        end
    end

    assign o_Tx_Serial = serial_q;
    assign o_Tx_Active = active_q;
    assign o_Tx_Done   = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: four parameterisations share clock and reset; expected line
// bits are queued when a start is driven and popped at each bit centre.
module tb_uart_tx_serializer;

    logic       clk;
    logic       rst;
    logic [3:0] start;
    logic [7:0] tx_byte;
    logic [3:0] ser;
    logic [3:0] act;
    logic [3:0] dn;

    int checks;
    int errors;
    logic exp_q[$];

    // Per-instance configuration: 0 = 8N1, 1 = 8E1, 2 = 8O1, 3 = 8N2 at 868 clocks per bit.
    int cpb_t [4] = '{4, 4, 4, 868};
    int pe_t  [4] = '{0, 1, 1, 0};
    int odd_t [4] = '{0, 0, 1, 0};
    int stp_t [4] = '{1, 1, 1, 2};

    uart_tx_serializer #(.CLKS_PER_BIT(4), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(1))
    u_n1 (
        .i_Clk(clk), .i_Rst(rst), .i_Tx_Start(start[0]), .i_Tx_Byte(tx_byte),
        .o_Tx_Serial(ser[0]), .o_Tx_Active(act[0]), .o_Tx_Done(dn[0])
    );

    uart_tx_serializer #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .STOP_BITS(1))
    u_e1 (
        .i_Clk(clk), .i_Rst(rst), .i_Tx_Start(start[1]), .i_Tx_Byte(tx_byte),
        .o_Tx_Serial(ser[1]), .o_Tx_Active(act[1]), .o_Tx_Done(dn[1])
    );

    uart_tx_serializer #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b1), .STOP_BITS(1))
    u_o1 (
        .i_Clk(clk), .i_Rst(rst), .i_Tx_Start(start[2]), .i_Tx_Byte(tx_byte),
        .o_Tx_Serial(ser[2]), .o_Tx_Active(act[2]), .o_Tx_Done(dn[2])
    );

    uart_tx_serializer #(.CLKS_PER_BIT(868), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(2))
    u_n2 (
        .i_Clk(clk), .i_Rst(rst), .i_Tx_Start(start[3]), .i_Tx_Byte(tx_byte),
        .o_Tx_Serial(ser[3]), .o_Tx_Active(act[3]), .o_Tx_Done(dn[3])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int frame_cycles(input int s);
        return (1 + 8 + pe_t[s] + stp_t[s]) * cpb_t[s];
    endfunction

    task automatic push_frame(input int s, input logic [7:0] b);
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
        if (pe_t[s] != 0) exp_q.push_back((^b) ^ odd_t[s][0]);
        for (int i = 0; i < stp_t[s]; i++) exp_q.push_back(1'b1);
    endtask

    // Returns 1 ns after the accepting edge, so the next negedge lies in the first low cycle.
    task automatic send(input int s, input logic [7:0] b, input bit keep);
        @(posedge clk);
        #1;
        tx_byte  = b;
        start[s] = 1'b1;
        push_frame(s, b);
        @(posedge clk);
        #1;
        if (!keep) start[s] = 1'b0;
    endtask

    task automatic check_frame(input int s, input logic [7:0] next_byte, input bit hold_start,
                               input bit pokes, input bit tail);
        int n;
        int act_cnt;
        int done_cnt;
        logic e;
        n = frame_cycles(s);
        act_cnt = 0;
        done_cnt = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (act[s] === 1'b1) act_cnt++;
            if (dn[s] !== 1'b0) done_cnt++;
            if (c % cpb_t[s] == cpb_t[s] / 2) begin
                if (exp_q.size() == 0) begin
                    chk("scoreboard_empty", 32'd0, 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("line_s%0d_bit%0d", s, c / cpb_t[s]), 32'(ser[s]), 32'(e));
                end
            end
            if (c == 1) begin
                tx_byte  = next_byte;
                start[s] = hold_start;
            end
            if (pokes) start[s] = (c == 5 || c == 12 || c == 30);
        end
        chk($sformatf("active_len_s%0d", s), act_cnt, n);
        chk($sformatf("no_early_done_s%0d", s), done_cnt, 0);
        @(negedge clk);
        chk($sformatf("done_pulse_s%0d", s), {act[s], dn[s], ser[s]}, 3'b011);
        if (tail) begin
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                chk($sformatf("idle_after_s%0d", s), {act[s], dn[s], ser[s]}, 3'b001);
            end
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        start   = '0;
        tx_byte = '0;
        rst     = 1'b1;
        #12;
        for (int s = 0; s < 4; s++)
            chk($sformatf("reset_s%0d", s), {act[s], dn[s], ser[s]}, 3'b001);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_line", 32'(ser), 32'hF);

        // Single 8N1 frame, byte changed after acceptance.
        send(0, 8'hA5, 1'b0);
        check_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1);

        // Start held high: two contiguous frames.
        send(0, 8'h00, 1'b1);
        check_frame(0, 8'hFF, 1'b1, 1'b0, 1'b0);
        push_frame(0, 8'hFF);
        check_frame(0, 8'h81, 1'b0, 1'b0, 1'b1);

        // Start pulses mid-frame are ignored.
        send(0, 8'hC3, 1'b0);
        check_frame(0, 8'hC3, 1'b0, 1'b1, 1'b1);

        // Asynchronous reset in the middle of the data bits.
        send(0, 8'h96, 1'b0);
        repeat (14) @(negedge clk);
        chk("active_before_rst", 32'(act[0]), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_line", {act[0], ser[0]}, 2'b01);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        begin
            int bad;
            bad = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if ({act[0], dn[0], ser[0]} !== 3'b001) bad++;
            end
            chk("idle_after_rst", bad, 0);
        end
        send(0, 8'h3C, 1'b0);
        check_frame(0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Parity frames: 0x07 has odd weight.
        send(1, 8'h07, 1'b0);
        check_frame(1, 8'h00, 1'b0, 1'b0, 1'b1);
        send(2, 8'h07, 1'b0);
        check_frame(2, 8'h00, 1'b0, 1'b0, 1'b1);
        send(1, 8'hB4, 1'b0);
        check_frame(1, 8'h00, 1'b0, 1'b0, 1'b1);

        // Full-rate frame with two stop bits.
        send(3, 8'h55, 1'b0);
        check_frame(3, 8'h00, 1'b0, 1'b0, 1'b1);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
